operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Read side of the register file; counterpart of the writeback stage. Takes decoded ops, reads
//  rs/rt/rd and CPSR through the regFile exe_* ports, and forwards same-cycle wb_* writes.
//  Stalls on RAW/WAW hazards using a per-register pending scoreboard that writeback clears.
//  Emits a registered operand bundle to execute over a valid/ready handshake.
// PARAMETERS
//  NUM_REGS   16  architectural registers
//  REG_NUM_W  4   register index width
//  DATA_W     32  data / CPSR width
// PORTS
//  clk             in   1         rising-edge clock
//  reset           in   1         synchronous, active-high
//  in_valid        in   1         decoded op present
//  in_ready        out  1         op accepted this cycle
//  in_rd_num       in   REG_NUM_W destination register
//  in_rs_num       in   REG_NUM_W source 1
//  in_rt_num       in   REG_NUM_W source 2
//  in_uses_rs      in   1         op reads rs
//  in_uses_rt      in   1         op reads rt
//  in_uses_rd      in   1         op reads rd as a source (e.g. store data)
//  in_uses_cpsr    in   1         op reads flags (conditional op)
//  in_is_alu_op    in   1         op writes rd from ALU result
//  in_is_cmp_op    in   1         op writes CPSR
//  in_is_ld_op     in   1         op writes rd from dmem
//  exe_rd_num/exe_rs_num/exe_rt_num  out REG_NUM_W  regFile read addresses (= in_*_num, comb.)
//  exe_rd_data_out/exe_rs_data_out/exe_rt_data_out/exe_cpsr_out  in DATA_W  regFile read data
//  wb_rd_num       in   REG_NUM_W writeback destination
//  wb_rd_write_en  in   1         writeback register write
//  wb_rd_in        in   DATA_W    writeback register data
//  wb_cpsr_write_en in  1         writeback CPSR write
//  wb_cpsr_in      in   DATA_W    writeback CPSR data
//  out_valid       out  1         bundle valid to execute
//  out_ready       in   1         execute accepts bundle
//  out_rd_num      out  REG_NUM_W registered destination
//  out_rd_val/out_rs_val/out_rt_val/out_cpsr  out DATA_W  registered operands
//  out_is_alu_op/out_is_cmp_op/out_is_ld_op   out 1       registered op class
// BEHAVIOUR
//  - Reset: out_valid=0, all out_* = 0, pending[NUM_REGS-1:0]=0, cpsr_pending=0. Any in-flight
//    bundle is dropped. The first in_ready is possible in the cycle after reset deasserts.
//  - Operand select: if wb_rd_write_en && wb_rd_num==src, use wb_rd_in; else use regFile data.
//    CPSR: use wb_cpsr_in if wb_cpsr_write_en, else exe_cpsr_out.
//  - Hazard: a source is blocked if it is used, pending[src]=1, and it is not being written by
//    wb this cycle. cpsr is blocked if in_uses_cpsr, cpsr_pending=1, and !wb_cpsr_write_en.
//    WAW: the op writes rd (alu|ld) and pending[rd]=1 with no same-cycle wb to rd.
//    Likewise a cmp op with cpsr_pending set and no wb_cpsr_write_en.
//    stall = any of these blocked.
//  - in_ready = !stall && (!out_valid || out_ready). Combinational; in_ready may fall with
//    in_valid low.
//  - Accept (in_valid && in_ready): latch the bundle next edge with out_valid=1. Latency is
//    1 cycle. Set pending[in_rd_num] if alu|ld. Set cpsr_pending if cmp.
//  - out_valid && out_ready && no accept: out_valid clears. out_* hold while out_valid && !out_ready.
//  - Scoreboard clear: wb_rd_write_en clears pending[wb_rd_num]; wb_cpsr_write_en clears
//    cpsr_pending. Same-cycle set and clear of one bit: set wins (new writer issued).
//  - r0 gets no special treatment; all NUM_REGS are scoreboarded.
//  - alu|ld with is_cmp also set: both scoreboard bits set. is_alu and is_ld both set: one rd write.
// TESTING
//  1 reset; issue alu r3 (rs=r1,rt=r2) with regfile r1=5,r2=7 -> out_valid next cycle,
//    out_rs_val=5, out_rt_val=7, pending[3]=1.
//  2 then alu uses_rs r3 with no wb -> in_ready=0 held. Drive wb r3=0x2A -> same-cycle
//    in_ready=1, out_rs_val=0x2A, and pending[3] stays 1 (new writer wins).
//  3 cmp issued, then a cond op with uses_cpsr -> stall until wb_cpsr_write_en with
//    cpsr_in=0x8 -> out_cpsr=0x8.
//  4 WAW: two ld r4 back-to-back -> second stalls until wb r4. No stall for an unrelated ld r5.
//  5 out_ready=0 for 3 cycles with a valid bundle -> out_* stable and in_ready=0. Release ->
//    next op latched the cycle after.
//  6 reset asserted with pending[3]=1 and out_valid=1 -> next cycle out_valid=0 and the
//    scoreboard is clear. A source read of r3 is not stalled.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads sources from the register file, forwards same-cycle writeback,
// stalls on RAW/WAW hazards via a pending-writer scoreboard, and registers a bundle for execute.
module operand_fetch #(
    parameter int NUM_REGS  = 16,
    parameter int REG_NUM_W = 4,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_NUM_W-1:0] in_rd_num,
    input  logic [REG_NUM_W-1:0] in_rs_num,
    input  logic [REG_NUM_W-1:0] in_rt_num,
    input  logic                 in_uses_rs,
    input  logic                 in_uses_rt,
    input  logic                 in_uses_rd,
    input  logic                 in_uses_cpsr,
    input  logic                 in_is_alu_op,
    input  logic                 in_is_cmp_op,
    input  logic                 in_is_ld_op,
    output logic [REG_NUM_W-1:0] exe_rd_num,
    output logic [REG_NUM_W-1:0] exe_rs_num,
    output logic [REG_NUM_W-1:0] exe_rt_num,
    input  logic [DATA_W-1:0]    exe_rd_data_out,
    input  logic [DATA_W-1:0]    exe_rs_data_out,
    input  logic [DATA_W-1:0]    exe_rt_data_out,
    input  logic [DATA_W-1:0]    exe_cpsr_out,
    input  logic [REG_NUM_W-1:0] wb_rd_num,
    input  logic                 wb_rd_write_en,
    input  logic [DATA_W-1:0]    wb_rd_in,
    input  logic                 wb_cpsr_write_en,
    input  logic [DATA_W-1:0]    wb_cpsr_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_NUM_W-1:0] out_rd_num,
    output logic [DATA_W-1:0]    out_rd_val,
    output logic [DATA_W-1:0]    out_rs_val,
    output logic [DATA_W-1:0]    out_rt_val,
    output logic [DATA_W-1:0]    out_cpsr,
    output logic                 out_is_alu_op,
    output logic                 out_is_cmp_op,
    output logic                 out_is_ld_op
);

    logic [NUM_REGS-1:0]  pending_q, pending_d;
    logic                 cpsr_pending_q, cpsr_pending_d;
    logic                 out_valid_q, out_valid_d;
    logic [REG_NUM_W-1:0] out_rd_num_q, out_rd_num_d;
    logic [DATA_W-1:0]    out_rd_val_q, out_rd_val_d;
    logic [DATA_W-1:0]    out_rs_val_q, out_rs_val_d;
    logic [DATA_W-1:0]    out_rt_val_q, out_rt_val_d;
    logic [DATA_W-1:0]    out_cpsr_q, out_cpsr_d;
    logic                 out_is_alu_q, out_is_alu_d;
    logic                 out_is_cmp_q, out_is_cmp_d;
    logic                 out_is_ld_q, out_is_ld_d;

    logic                 wb_hits_rd, wb_hits_rs, wb_hits_rt;
    logic [DATA_W-1:0]    rd_val, rs_val, rt_val, cpsr_val;
    logic                 writes_rd, stall, accept;

    assign exe_rd_num = in_rd_num;
    assign exe_rs_num = in_rs_num;
    assign exe_rt_num = in_rt_num;

    always_comb begin
        wb_hits_rd = wb_rd_write_en && (wb_rd_num == in_rd_num);
        wb_hits_rs = wb_rd_write_en && (wb_rd_num == in_rs_num);
        wb_hits_rt = wb_rd_write_en && (wb_rd_num == in_rt_num);

        rd_val   = wb_hits_rd ? wb_rd_in : exe_rd_data_out;
        rs_val   = wb_hits_rs ? wb_rd_in : exe_rs_data_out;
        rt_val   = wb_hits_rt ? wb_rd_in : exe_rt_data_out;
        cpsr_val = wb_cpsr_write_en ? wb_cpsr_in : exe_cpsr_out;

        writes_rd = in_is_alu_op || in_is_ld_op;

        // A pending bit being cleared this cycle is already satisfied by forwarding.
        stall = (in_uses_rs && pending_q[in_rs_num] && !wb_hits_rs)
             || (in_uses_rt && pending_q[in_rt_num] && !wb_hits_rt)
             || (in_uses_rd && pending_q[in_rd_num] && !wb_hits_rd)
             || (writes_rd && pending_q[in_rd_num] && !wb_hits_rd)
             || (in_uses_cpsr && cpsr_pending_q && !wb_cpsr_write_en)
             || (in_is_cmp_op && cpsr_pending_q && !wb_cpsr_write_en);

        in_ready = !stall && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;

        // Clear first, then set, so a newly issued writer wins over a retiring one.
        pending_d      = pending_q;
        cpsr_pending_d = cpsr_pending_q;
        if (wb_rd_write_en)      pending_d[wb_rd_num] = 1'b0;
        if (wb_cpsr_write_en)    cpsr_pending_d       = 1'b0;
        if (accept && writes_rd) pending_d[in_rd_num] = 1'b1;
        if (accept && in_is_cmp_op) cpsr_pending_d    = 1'b1;

        out_valid_d  = out_valid_q;
        out_rd_num_d = out_rd_num_q;
        out_rd_val_d = out_rd_val_q;
        out_rs_val_d = out_rs_val_q;
        out_rt_val_d = out_rt_val_q;
        out_cpsr_d   = out_cpsr_q;
        out_is_alu_d = out_is_alu_q;
        out_is_cmp_d = out_is_cmp_q;
        out_is_ld_d  = out_is_ld_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_rd_num_d = in_rd_num;
            out_rd_val_d = rd_val;
            out_rs_val_d = rs_val;
            out_rt_val_d = rt_val;
            out_cpsr_d   = cpsr_val;
            out_is_alu_d = in_is_alu_op;
            out_is_cmp_d = in_is_cmp_op;
            out_is_ld_d  = in_is_ld_op;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q      <= '0;
            cpsr_pending_q <= 1'b0;
            out_valid_q    <= 1'b0;
            out_rd_num_q   <= '0;
            out_rd_val_q   <= '0;
            out_rs_val_q   <= '0;
            out_rt_val_q   <= '0;
            out_cpsr_q     <= '0;
            out_is_alu_q   <= 1'b0;
            out_is_cmp_q   <= 1'b0;
            out_is_ld_q    <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            cpsr_pending_q <= cpsr_pending_d;
            out_valid_q    <= out_valid_d;
            out_rd_num_q   <= out_rd_num_d;
            out_rd_val_q   <= out_rd_val_d;
            out_rs_val_q   <= out_rs_val_d;
            out_rt_val_q   <= out_rt_val_d;
            out_cpsr_q     <= out_cpsr_d;
            out_is_alu_q   <= out_is_alu_d;
            out_is_cmp_q   <= out_is_cmp_d;
            out_is_ld_q    <= out_is_ld_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_rd_num    = out_rd_num_q;
    assign out_rd_val    = out_rd_val_q;
    assign out_rs_val    = out_rs_val_q;
    assign out_rt_val    = out_rt_val_q;
    assign out_cpsr      = out_cpsr_q;
    assign out_is_alu_op = out_is_alu_q;
    assign out_is_cmp_op = out_is_cmp_q;
    assign out_is_ld_op  = out_is_ld_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register-file model on the exe_* ports, expected bundles queued at
// issue and compared when execute consumes them, plus inline handshake/stall checks per scenario.
module tb_operand_fetch;

    localparam int NUM_REGS  = 16;
    localparam int REG_NUM_W = 4;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic [REG_NUM_W-1:0] rd_num;
        logic [DATA_W-1:0]    rd_val;
        logic [DATA_W-1:0]    rs_val;
        logic [DATA_W-1:0]    rt_val;
        logic [DATA_W-1:0]    cpsr;
        logic                 alu;
        logic                 cmp;
        logic                 ld;
    } bundle_t;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, in_ready;
    logic [REG_NUM_W-1:0] in_rd_num, in_rs_num, in_rt_num;
    logic in_uses_rs, in_uses_rt, in_uses_rd, in_uses_cpsr;
    logic in_is_alu_op, in_is_cmp_op, in_is_ld_op;
    logic [REG_NUM_W-1:0] exe_rd_num, exe_rs_num, exe_rt_num;
    logic [DATA_W-1:0] exe_rd_data_out, exe_rs_data_out, exe_rt_data_out, exe_cpsr_out;
    logic [REG_NUM_W-1:0] wb_rd_num;
    logic wb_rd_write_en, wb_cpsr_write_en;
    logic [DATA_W-1:0] wb_rd_in, wb_cpsr_in;
    logic out_valid, out_ready;
    logic [REG_NUM_W-1:0] out_rd_num;
    logic [DATA_W-1:0] out_rd_val, out_rs_val, out_rt_val, out_cpsr;
    logic out_is_alu_op, out_is_cmp_op, out_is_ld_op;

    logic [DATA_W-1:0] rf [NUM_REGS];
    logic [DATA_W-1:0] rf_cpsr;

    bundle_t exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign exe_rd_data_out = rf[exe_rd_num];
    assign exe_rs_data_out = rf[exe_rs_num];
    assign exe_rt_data_out = rf[exe_rt_num];
    assign exe_cpsr_out    = rf_cpsr;

    operand_fetch #(.NUM_REGS(NUM_REGS), .REG_NUM_W(REG_NUM_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd_num(in_rd_num), .in_rs_num(in_rs_num), .in_rt_num(in_rt_num),
        .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt), .in_uses_rd(in_uses_rd),
        .in_uses_cpsr(in_uses_cpsr),
        .in_is_alu_op(in_is_alu_op), .in_is_cmp_op(in_is_cmp_op), .in_is_ld_op(in_is_ld_op),
        .exe_rd_num(exe_rd_num), .exe_rs_num(exe_rs_num), .exe_rt_num(exe_rt_num),
        .exe_rd_data_out(exe_rd_data_out), .exe_rs_data_out(exe_rs_data_out),
        .exe_rt_data_out(exe_rt_data_out), .exe_cpsr_out(exe_cpsr_out),
        .wb_rd_num(wb_rd_num), .wb_rd_write_en(wb_rd_write_en), .wb_rd_in(wb_rd_in),
        .wb_cpsr_write_en(wb_cpsr_write_en), .wb_cpsr_in(wb_cpsr_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd_num(out_rd_num), .out_rd_val(out_rd_val), .out_rs_val(out_rs_val),
        .out_rt_val(out_rt_val), .out_cpsr(out_cpsr),
        .out_is_alu_op(out_is_alu_op), .out_is_cmp_op(out_is_cmp_op), .out_is_ld_op(out_is_ld_op)
    );

    // Execute side: every consumed bundle must match the oldest expected one.
    always @(negedge clk) begin
        bundle_t got, e;
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            got = '{out_rd_num, out_rd_val, out_rs_val, out_rt_val, out_cpsr,
                    out_is_alu_op, out_is_cmp_op, out_is_ld_op};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bundle: got %h, required none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL bundle: got %h, required %h", got, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_rd_num = 0; in_rs_num = 0; in_rt_num = 0;
        in_uses_rs = 0; in_uses_rt = 0; in_uses_rd = 0; in_uses_cpsr = 0;
        in_is_alu_op = 0; in_is_cmp_op = 0; in_is_ld_op = 0;
        wb_rd_write_en = 0; wb_rd_num = 0; wb_rd_in = 0;
        wb_cpsr_write_en = 0; wb_cpsr_in = 0;
    endtask

    task automatic drive_op(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                            input logic urs, input logic urt, input logic ucp,
                            input logic alu, input logic cmp, input logic ld);
        in_valid = 1; in_rd_num = rd; in_rs_num = rs; in_rt_num = rt;
        in_uses_rs = urs; in_uses_rt = urt; in_uses_rd = 0; in_uses_cpsr = ucp;
        in_is_alu_op = alu; in_is_cmp_op = cmp; in_is_ld_op = ld;
    endtask

    task automatic push_exp(input logic [3:0] rd, input logic [31:0] rdv, input logic [31:0] rsv,
                            input logic [31:0] rtv, input logic [31:0] cp,
                            input logic alu, input logic cmp, input logic ld);
        bundle_t b;
        b = '{rd, rdv, rsv, rtv, cp, alu, cmp, ld};
        exp_q.push_back(b);
    endtask

    task automatic check_ready(input string name, input logic want);
        checks++;
        if (in_ready !== want) begin
            errors++;
            $display("FAIL %s: in_ready=%b, required %b", name, in_ready, want);
        end
    endtask

    task automatic test_reset();
        reset = 1; out_ready = 1; idle();
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
        checks++;
        if ({out_rd_num, out_rd_val, out_rs_val, out_rt_val, out_cpsr} !== '0) begin
            errors++; $display("FAIL reset_data: got %h %h %h %h, required 0", out_rd_val, out_rs_val, out_rt_val, out_cpsr);
        end
        checks++;
        if ({out_is_alu_op, out_is_cmp_op, out_is_ld_op} !== 3'b000) begin
            errors++; $display("FAIL reset_class: got %b%b%b, required 000", out_is_alu_op, out_is_cmp_op, out_is_ld_op);
        end
        reset = 0;
        #1;
        check_ready("ready_after_reset", 1'b1);
    endtask

    task automatic test_issue_alu();
        drive_op(4'd3, 4'd1, 4'd2, 1, 1, 0, 1, 0, 0);
        #1;
        check_ready("alu_issue", 1'b1);
        push_exp(4'd3, rf[3], 32'd5, 32'd7, rf_cpsr, 1, 0, 0);
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL alu_latency: out_valid=%b, required 1", out_valid); end
    endtask

    task automatic test_raw_forward();
        drive_op(4'd3, 4'd3, 4'd0, 1, 0, 0, 1, 0, 0);
        #1;
        check_ready("raw_stall_c0", 1'b0);
        tick();
        check_ready("raw_stall_c1", 1'b0);
        wb_rd_write_en = 1; wb_rd_num = 4'd3; wb_rd_in = 32'h2A;
        #1;
        check_ready("raw_wb_release", 1'b1);
        push_exp(4'd3, 32'h2A, 32'h2A, rf[0], rf_cpsr, 1, 0, 0);
        tick();
        idle();
        drive_op(4'd7, 4'd3, 4'd0, 1, 0, 0, 1, 0, 0);
        #1;
        check_ready("pending3_kept", 1'b0);
        idle();
        wb_rd_write_en = 1; wb_rd_num = 4'd3; wb_rd_in = 32'h55;
        tick();
        rf[3] = 32'h55;
        idle();
    endtask

    task automatic test_cpsr_hazard();
        drive_op(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 0);
        #1;
        check_ready("cmp_issue", 1'b1);
        push_exp(4'd0, rf[0], rf[0], rf[0], rf_cpsr, 0, 1, 0);
        tick();
        drive_op(4'd8, 4'd1, 4'd0, 1, 0, 1, 1, 0, 0);
        #1;
        check_ready("cpsr_stall_c0", 1'b0);
        tick();
        check_ready("cpsr_stall_c1", 1'b0);
        wb_cpsr_write_en = 1; wb_cpsr_in = 32'h8;
        #1;
        check_ready("cpsr_release", 1'b1);
        push_exp(4'd8, rf[8], 32'd5, rf[0], 32'h8, 1, 0, 0);
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        drive_op(4'd4, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1);
        #1;
        check_ready("ld4_first", 1'b1);
        push_exp(4'd4, rf[4], rf[0], rf[0], rf_cpsr, 0, 0, 1);
        tick();
        drive_op(4'd4, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1);
        #1;
        check_ready("waw_ld4_stall", 1'b0);
        drive_op(4'd5, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1);
        #1;
        check_ready("ld5_unrelated", 1'b1);
        push_exp(4'd5, rf[5], rf[0], rf[0], rf_cpsr, 0, 0, 1);
        tick();
        drive_op(4'd4, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1);
        #1;
        check_ready("waw_ld4_still", 1'b0);
        tick();
        wb_rd_write_en = 1; wb_rd_num = 4'd4; wb_rd_in = 32'h44;
        #1;
        check_ready("waw_release", 1'b1);
        push_exp(4'd4, 32'h44, rf[0], rf[0], rf_cpsr, 0, 0, 1);
        tick();
        idle();
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        drive_op(4'd9, 4'd1, 4'd2, 1, 1, 0, 1, 0, 0);
        #1;
        check_ready("bp_first_issue", 1'b1);
        push_exp(4'd9, rf[9], 32'd5, 32'd7, rf_cpsr, 1, 0, 0);
        tick();
        drive_op(4'd10, 4'd2, 4'd0, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_ready("bp_blocked", 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_rd_num !== 4'd9 || out_rs_val !== 32'd5 || out_rt_val !== 32'd7) begin
                errors++;
                $display("FAIL bp_hold: valid=%b rd=%0d rs=%h rt=%h, required 1 9 5 7",
                         out_valid, out_rd_num, out_rs_val, out_rt_val);
            end
            tick();
        end
        out_ready = 1;
        #1;
        check_ready("bp_release", 1'b1);
        push_exp(4'd10, rf[10], 32'd7, rf[0], rf_cpsr, 1, 0, 0);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_rd_num !== 4'd10) begin
            errors++; $display("FAIL bp_next_latched: valid=%b rd=%0d, required 1 10", out_valid, out_rd_num);
        end
        idle();
        tick();
    endtask

    task automatic test_reset_midflight();
        out_ready = 0;
        drive_op(4'd3, 4'd1, 4'd0, 1, 0, 0, 1, 0, 0);
        tick();
        idle();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b, required 1", out_valid); end
        reset = 1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_rd_num !== 4'd0 || out_rs_val !== '0) begin
            errors++; $display("FAIL midflight_reset: valid=%b rd=%0d rs=%h, required 0 0 0", out_valid, out_rd_num, out_rs_val);
        end
        reset = 0;
        out_ready = 1;
        drive_op(4'd11, 4'd3, 4'd0, 1, 0, 0, 1, 0, 0);
        #1;
        check_ready("r3_after_reset", 1'b1);
        push_exp(4'd11, rf[11], 32'h55, rf[0], rf_cpsr, 1, 0, 0);
        tick();
        idle();
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL drain: %0d bundles outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'h100 + i;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        rf_cpsr = 32'h3;
        test_reset();
        test_issue_alu();
        test_raw_forward();
        test_cpsr_hazard();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
